falling_objects_mover: RTL and testbench

//  Moves NUM_OBJ independent falling objects (hoops/power-ups) down the 640x480 screen in fixed point, one step per frame.

---
 rtl/falling_objects_mover.sv | 125 ++++++++++++
 tb/tb_falling_objects_mover.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/falling_objects_mover.sv
// Moves NUM_OBJ falling objects down the screen in fixed point, one step per frame,
// respawning them above the screen at an LFSR-derived X on bottom exit or collision.
module falling_objects_mover #(
  parameter int          NUM_OBJ    = 4,
  parameter int          FALL_SPEED = 100,
  parameter int          FP_SHIFT   = 6,
  parameter int          OBJ_W      = 28,
  parameter int          OBJ_H      = 58,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          STAGGER    = 120,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic                      pause,
  input  logic [1:0]                speedLevel,
  input  logic signed [10:0]        spawnX,
  input  logic [NUM_OBJ-1:0]        collision,
  output logic [NUM_OBJ*11-1:0]     topLeftX,
  output logic [NUM_OBJ*11-1:0]     topLeftY,
  output logic [NUM_OBJ-1:0]        respawnPulse
);

  localparam int                 SPAN     = SCREEN_W - OBJ_W;
  localparam logic signed [17:0] SPAWN_Y  = 18'(-(OBJ_H << FP_SHIFT));
  localparam logic signed [17:0] WRAP_FP  = 18'(SCREEN_W << FP_SHIFT);
  localparam logic signed [10:0] SCR_W_PX = 11'(SCREEN_W);
  localparam logic signed [10:0] SCR_H_PX = 11'(SCREEN_H);

  logic signed [17:0] x_q [NUM_OBJ];
  logic signed [17:0] x_d [NUM_OBJ];
  logic signed [17:0] y_q [NUM_OBJ];
  logic signed [17:0] y_d [NUM_OBJ];
  logic signed [10:0] x_pix [NUM_OBJ];
  logic signed [10:0] y_pix [NUM_OBJ];

  logic [NUM_OBJ-1:0] pending_q, pending_d;
  logic [NUM_OBJ-1:0] pulse_q, pulse_d;
  logic [15:0]        lfsr_q, lfsr_d;

  logic [NUM_OBJ-1:0] exit_now;
  logic [NUM_OBJ-1:0] eligible;
  logic [NUM_OBJ-1:0] svc;
  logic [10:0]        r_val;
  logic signed [17:0] spawn_sum;
  logic signed [17:0] spawn_fp;
  logic signed [17:0] step_fp;
  logic               frame_go;

  always_comb begin
    logic found;
    found     = 1'b0;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    r_val     = {1'b0, lfsr_q[9:0]};
    if (r_val >= 11'(SPAN)) r_val = r_val - 11'(SPAN);
    spawn_sum = {{7{spawnX[10]}}, spawnX} + {7'd0, r_val};
    spawn_fp  = spawn_sum <<< FP_SHIFT;
    step_fp   = 18'(FALL_SPEED * (int'(speedLevel) + 1));
    frame_go  = startOfFrame & ~pause;

    for (int i = 0; i < NUM_OBJ; i++) begin
      x_pix[i]    = x_q[i][FP_SHIFT +: 11];
      y_pix[i]    = y_q[i][FP_SHIFT +: 11];
      exit_now[i] = startOfFrame && (y_pix[i] > SCR_H_PX);
    end
    eligible = pending_q | exit_now;

    // Only the lowest eligible index is serviced; the rest wait frozen.
    svc = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (frame_go && eligible[i] && !found) begin
        svc[i] = 1'b1;
        found  = 1'b1;
      end
    end

    for (int i = 0; i < NUM_OBJ; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (frame_go) begin
        if (svc[i]) begin
          x_d[i] = spawn_fp;
          y_d[i] = SPAWN_Y;
        end else begin
          if (!eligible[i]) y_d[i] = y_q[i] + step_fp;
          if (x_pix[i] > SCR_W_PX) x_d[i] = x_q[i] - WRAP_FP;
        end
      end
    end

    // A collision on the frame cycle itself re-arms pending for the next frame.
    pending_d = (eligible & ~svc) | collision;
    pulse_d   = svc;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i] <= 18'((i * (SCREEN_W / NUM_OBJ)) << FP_SHIFT);
        y_q[i] <= 18'(-((OBJ_H + i * STAGGER) << FP_SHIFT));
      end
      pending_q <= '0;
      pulse_q   <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      lfsr_q    <= lfsr_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_out
    assign topLeftX[11*g +: 11] = x_q[g][FP_SHIFT +: 11];
    assign topLeftY[11*g +: 11] = y_q[g][FP_SHIFT +: 11];
  end

  assign respawnPulse = pulse_q;

endmodule

// File: tb/tb_falling_objects_mover.sv
// Randomised and directed stimulus against a frame-level reference model of the
// falling objects mover; expected outputs flow through a scoreboard queue.
module tb_falling_objects_mover;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              pause;
  logic [1:0]        speedLevel;
  logic signed [10:0] spawnX;
  logic [N-1:0]      collision;
  logic [N*11-1:0]   topLeftX;
  logic [N*11-1:0]   topLeftY;
  logic [N-1:0]      respawnPulse;

  always #5 clk = ~clk;

  falling_objects_mover dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
    .speedLevel(speedLevel), .spawnX(spawnX), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .respawnPulse(respawnPulse)
  );

  typedef struct {
    logic [N*11-1:0] x;
    logic [N*11-1:0] y;
    logic [N-1:0]    p;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  int        mx [N];
  int        my [N];
  bit        mp [N];
  bit [N-1:0] mpulse;
  bit [15:0] mlfsr;

  function automatic int pix(input int v);
    int p;
    p = (v >>> 6) & 2047;
    if (p >= 1024) p -= 2048;
    return p;
  endfunction

  function automatic int wrap18(input int v);
    int w;
    w = v & 32'h3FFFF;
    if (w >= 131072) w -= 262144;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = i * 160 * 64;
      my[i] = -(58 + 120 * i) * 64;
      mp[i] = 1'b0;
    end
    mpulse = '0;
    mlfsr  = 16'hACE1;
  endtask

  task automatic model_clock(input bit rn, input bit sof, input bit pz,
                             input int sl, input int sx, input bit [N-1:0] col);
    int  r, svc;
    bit  exit_f [N];
    bit  elig [N];
    int  oldx;
    if (!rn) begin
      model_reset();
      return;
    end
    r = int'(mlfsr[9:0]);
    if (r >= 612) r -= 612;
    svc = -1;
    for (int i = 0; i < N; i++) begin
      exit_f[i] = sof && (pix(my[i]) > 480);
      elig[i]   = mp[i] || exit_f[i];
    end
    if (sof && !pz)
      for (int i = N - 1; i >= 0; i--) if (elig[i]) svc = i;
    mpulse = '0;
    for (int i = 0; i < N; i++) begin
      oldx = pix(mx[i]);
      if (sof && !pz) begin
        if (i == svc) begin
          my[i] = -58 * 64;
          mx[i] = wrap18((sx + r) * 64);
          mpulse[i] = 1'b1;
        end else begin
          if (!elig[i]) my[i] = wrap18(my[i] + 100 * (sl + 1));
          if (oldx > 640) mx[i] = wrap18(mx[i] - 640 * 64);
        end
      end
      mp[i] = (elig[i] && i != svc) || col[i];
    end
    mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  endtask

  task automatic push_expected();
    exp_t e;
    int   t;
    for (int i = 0; i < N; i++) begin
      t = pix(mx[i]);
      e.x[11*i +: 11] = t[10:0];
      t = pix(my[i]);
      e.y[11*i +: 11] = t[10:0];
    end
    e.p = mpulse;
    sbq.push_back(e);
  endtask

  task automatic cyc(input bit rn, input bit sof, input bit pz, input int sl,
                     input int sx, input bit [N-1:0] col);
    @(negedge clk);
    resetN       = rn;
    startOfFrame = sof;
    pause        = pz;
    speedLevel   = 2'(sl);
    spawnX       = 11'(sx);
    collision    = col;
    model_clock(rn, sof, pz, sl, sx, col);
    push_expected();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit pz, input int sl, input int sx);
    cyc(1'b1, 1'b1, pz, sl, sx, '0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, pz, sl, sx, '0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int dx(input int i);
    logic [10:0] t;
    t = topLeftX[11*i +: 11];
    return int'($signed(t));
  endfunction

  function automatic int dy(input int i);
    logic [10:0] t;
    t = topLeftY[11*i +: 11];
    return int'($signed(t));
  endfunction

  task automatic chk_reset_values(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), dx(i), 160 * i);
      chk($sformatf("%s_y%0d", tag, i), dy(i), -(58 + 120 * i));
    end
    chk({tag, "_pulse"}, int'(respawnPulse), 0);
  endtask

  // Scoreboard monitor: one expected entry per clock after stimulus begins.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (topLeftX !== e.x) begin
          failures++;
          $display("FAIL sb_x t=%0t got=%h expected=%h", $time, topLeftX, e.x);
        end
        checks++;
        if (topLeftY !== e.y) begin
          failures++;
          $display("FAIL sb_y t=%0t got=%h expected=%h", $time, topLeftY, e.y);
        end
        checks++;
        if (respawnPulse !== e.p) begin
          failures++;
          $display("FAIL sb_pulse t=%0t got=%b expected=%b", $time, respawnPulse, e.p);
        end
      end
    end
  end

  initial begin
    int y0_hold [N];
    int guard;
    int xr;
    resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0;
    speedLevel = 2'd0; spawnX = '0; collision = '0;

    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 0, 100, '0);
    chk_reset_values("rst");

    for (int f = 0; f < 64; f++) frame(1'b0, 0, 100);
    chk("fall64_y0", dy(0), 42);
    chk("fall64_y1", dy(1), -78);
    chk("fall64_y3", dy(3), -318);
    chk("fall64_x2", dx(2), 320);

    cyc(1'b1, 1'b0, 1'b0, 0, 100, 4'b0110);
    cyc(1'b1, 1'b1, 1'b0, 0, 100, '0);
    chk("coll_pulse1", int'(respawnPulse), 2);
    chk("coll_y1", dy(1), -58);
    chk("coll_y2_frozen", dy(2), -198);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 0, 100, '0);
    chk("coll_pulse_clear", int'(respawnPulse), 0);
    cyc(1'b1, 1'b1, 1'b0, 0, 100, '0);
    chk("coll_pulse2", int'(respawnPulse), 4);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 0, 100, '0);

    cyc(1'b1, 1'b0, 1'b0, 0, 100, 4'b1000);
    for (int i = 0; i < N; i++) y0_hold[i] = dy(i);
    for (int f = 0; f < 10; f++) begin
      frame(1'b1, 3, 100);
      chk("pause_pulse", int'(respawnPulse), 0);
    end
    for (int i = 0; i < N; i++) chk($sformatf("pause_y%0d", i), dy(i), y0_hold[i]);
    cyc(1'b1, 1'b1, 1'b0, 0, 100, '0);
    chk("unpause_pulse3", int'(respawnPulse), 8);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 0, 100, '0);

    guard = 0;
    while (pix(my[0]) <= 480 && guard < 300) begin
      frame(1'b0, 3, 200);
      guard++;
    end
    chk("exit_reached", int'(pix(my[0]) > 480), 1);
    cyc(1'b1, 1'b0, 1'b0, 3, 200, 4'b0001);
    cyc(1'b1, 1'b1, 1'b0, 3, 200, '0);
    chk("exit_coll_pulse0", int'(respawnPulse[0]), 1);
    xr = dx(0);
    chk("exit_x_range", int'(xr >= 200 && xr <= 811), 1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 3, 200, '0);
    cyc(1'b1, 1'b1, 1'b0, 3, 200, '0);
    chk("exit_single_pulse0", int'(respawnPulse[0]), 0);

    for (int c = 0; c < 1200; c++) begin
      bit [N-1:0] col;
      for (int i = 0; i < N; i++) col[i] = ($urandom_range(0, 23) == 0);
      if (c == 600) begin
        cyc(1'b0, 1'b1, 1'b0, 1, 300, col);
        chk_reset_values("midrst");
      end else begin
        cyc(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3), $urandom_range(0, 600), col);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
